// File: rtl/ram_dual_read_port_pkg.sv
// Shared defaults and types for the dual-read-port RAM and its clear sequencer.
// The defaults describe the register/data file configuration.
package ram_dual_read_port_pkg;
    localparam int RAM_DATA_W_DEF   = 16;
    localparam int RAM_ADDR_W_DEF   = 8;
    localparam int RAM_MEM_SIZE_DEF = 256;

    typedef enum logic {
        SEQ_CLEAR = 1'b0,
        SEQ_DONE  = 1'b1
    } seq_state_t;
endpackage

// File: rtl/ram_clear_sequencer.sv
// Post-reset zero-fill sweep: one word per cycle from address 0 up to MEM_SIZE-1.
// Once the last word has been written, the done flag holds until the next reset.
module ram_clear_sequencer
    import ram_dual_read_port_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_W_DEF,
    parameter int MEM_SIZE   = RAM_MEM_SIZE_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] clear_ptr,
    output logic                  clear_we,
    output logic                  clear_done
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

    seq_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= SEQ_CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        clear_we   = 1'b0;
        case (state_reg)
            SEQ_CLEAR: begin
                clear_we = 1'b1;
                if (ptr_reg == LAST_ADDR) begin
                    state_next = SEQ_DONE;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    assign clear_ptr  = ptr_reg;
    assign clear_done = (state_reg == SEQ_DONE);
endmodule

// File: rtl/ram_dual_read_port.sv
// Single-clock RAM with one write port and two registered read-first read ports.
// Contents are zero-filled by the clear sequencer after every reset.
module ram_dual_read_port
    import ram_dual_read_port_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_W_DEF,
    parameter int ADDR_WIDTH = RAM_ADDR_W_DEF,
    parameter int MEM_SIZE   = RAM_MEM_SIZE_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iWriteEnable,
    input  logic [ADDR_WIDTH-1:0] iWriteAddress,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic [ADDR_WIDTH-1:0] iReadAddress0,
    input  logic [ADDR_WIDTH-1:0] iReadAddress1,
    output logic [DATA_WIDTH-1:0] oDataOut0,
    output logic [DATA_WIDTH-1:0] oDataOut1,
    output logic                  oClearDone
);
    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < SIZE_EXT;
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];

    logic [ADDR_WIDTH-1:0] clear_ptr;
    logic                  clear_we;
    logic                  clear_done;

    ram_clear_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) u_clear (
        .Clock      (Clock),
        .Reset      (Reset),
        .clear_ptr  (clear_ptr),
        .clear_we   (clear_we),
        .clear_done (clear_done)
    );

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    // The sweep owns the write port until it finishes; external writes are dropped meanwhile.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = iWriteAddress;
        wr_data = iDataIn;
        if (clear_we) begin
            wr_en   = 1'b1;
            wr_addr = clear_ptr;
            wr_data = '0;
        end else if (iWriteEnable && in_range(iWriteAddress)) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    logic [ADDR_WIDTH-1:0] rd_addr     [2];
    logic [DATA_WIDTH-1:0] rd_data_reg [2];

    assign rd_addr[0] = iReadAddress0;
    assign rd_addr[1] = iReadAddress1;

    // Reading in a separate process from the write gives read-first behaviour.
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                rd_data_reg[gi] <= '0;
            end else if (!clear_done || !in_range(rd_addr[gi])) begin
                rd_data_reg[gi] <= '0;
            end else begin
                rd_data_reg[gi] <= mem[rd_addr[gi][IDX_W-1:0]];
            end
        end
    end

    assign oDataOut0  = rd_data_reg[0];
    assign oDataOut1  = rd_data_reg[1];
    assign oClearDone = clear_done;
endmodule

// File: tb/tb_ram_dual_read_port.sv
// Directed bench for ram_dual_read_port: default 16x256 instance plus a 3-bit x 10000-word instance.
module tb_ram_dual_read_port;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;

    logic        a_we = 1'b0;
    logic [7:0]  a_waddr = '0;
    logic [15:0] a_din = '0;
    logic [7:0]  a_raddr0 = '0;
    logic [7:0]  a_raddr1 = '0;
    logic [15:0] a_out0, a_out1;
    logic        a_done;

    logic        b_we = 1'b0;
    logic [15:0] b_waddr = '0;
    logic [2:0]  b_din = '0;
    logic [15:0] b_raddr0 = '0;
    logic [15:0] b_raddr1 = '0;
    logic [2:0]  b_out0, b_out1;
    logic        b_done;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    ram_dual_read_port dut_a (
        .Clock(Clock), .Reset(Reset),
        .iWriteEnable(a_we), .iWriteAddress(a_waddr), .iDataIn(a_din),
        .iReadAddress0(a_raddr0), .iReadAddress1(a_raddr1),
        .oDataOut0(a_out0), .oDataOut1(a_out1), .oClearDone(a_done)
    );

    ram_dual_read_port #(.DATA_WIDTH(3), .ADDR_WIDTH(16), .MEM_SIZE(10000)) dut_b (
        .Clock(Clock), .Reset(Reset),
        .iWriteEnable(b_we), .iWriteAddress(b_waddr), .iDataIn(b_din),
        .iReadAddress0(b_raddr0), .iReadAddress1(b_raddr1),
        .oDataOut0(b_out0), .oDataOut1(b_out1), .oClearDone(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Counts edges from now until dut_a reports done; also tracks that both outputs stayed 0.
    task automatic wait_sweep(output int n, output bit zero_ok);
        n = 0;
        zero_ok = 1'b1;
        while (!a_done && n < 400) begin
            tick();
            n++;
            if (a_out0 !== 16'h0 || a_out1 !== 16'h0) zero_ok = 1'b0;
        end
    endtask

    initial begin
        int  n;
        bit  zero_ok;

        // Test 1 + 5: reset 3 cycles, then a write is held asserted through the whole sweep.
        repeat (3) begin
            tick();
            check("reset_out0", a_out0, 0);
            check("reset_out1", a_out1, 0);
            check("reset_done", a_done, 0);
        end
        a_we = 1'b1; a_waddr = 8'h20; a_din = 16'hFFFF;
        a_raddr0 = 8'h20; a_raddr1 = 8'h10;
        Reset = 1'b1;
        wait_sweep(n, zero_ok);
        a_we = 1'b0;
        check("sweep_cycles", n, 256);
        check("sweep_outputs_zero", {31'b0, zero_ok}, 1);
        check("sweep_done", a_done, 1);
        $display("txn sweep: cycles=%0d done=%0b", n, a_done);

        for (int a = 0; a < 256; a++) begin
            a_raddr0 = 8'(a);
            a_raddr1 = 8'(255 - a);
            tick();
            check("clear_read0", a_out0, 0);
            check("clear_read1", a_out1, 0);
        end
        $display("txn readall: all 256 words read through both ports");

        // Test 2: write then read back.
        a_we = 1'b1; a_waddr = 8'h10; a_din = 16'hA5A5; a_raddr0 = 8'h00;
        tick();
        a_we = 1'b0; a_raddr0 = 8'h10;
        tick();
        check("write_read_10", a_out0, 16'hA5A5);
        $display("txn write 0x10=A5A5 read0=%h", a_out0);

        // Test 3: read-during-write on both ports shows old data first.
        a_we = 1'b1; a_waddr = 8'h05; a_din = 16'h1234;
        a_raddr0 = 8'h05; a_raddr1 = 8'h05;
        tick();
        a_we = 1'b0;
        check("rdw_old0", a_out0, 0);
        check("rdw_old1", a_out1, 0);
        tick();
        check("rdw_new0", a_out0, 16'h1234);
        check("rdw_new1", a_out1, 16'h1234);
        $display("txn rdw 0x05: out0=%h out1=%h", a_out0, a_out1);

        a_raddr0 = 8'h10; a_raddr1 = 8'h05;
        tick();
        check("indep_read0", a_out0, 16'hA5A5);
        check("indep_read1", a_out1, 16'h1234);
        $display("txn indep read0=%h read1=%h", a_out0, a_out1);

        // Test 4: wide-address instance, in-range and out-of-range accesses.
        n = 0;
        while (!b_done && n < 11000) begin
            tick();
            n++;
        end
        check("big_done", b_done, 1);
        b_we = 1'b1; b_waddr = 16'd9999; b_din = 3'b101;
        tick();
        b_waddr = 16'd10000; b_din = 3'b111;
        tick();
        b_we = 1'b0; b_raddr0 = 16'd9999; b_raddr1 = 16'd10000;
        tick();
        check("big_read_9999", b_out0, 3'b101);
        check("big_read_10000", b_out1, 0);
        b_raddr0 = 16'd0; b_raddr1 = 16'd9999;
        tick();
        check("big_read_0", b_out0, 0);
        check("big_read_9999_p1", b_out1, 3'b101);
        b_raddr0 = 16'hFFFF;
        tick();
        check("big_read_ffff", b_out0, 0);
        $display("txn big: @9999=%b @10000/0/ffff reads zero", b_out1);

        // Test 6: async reset mid-operation, including a restart part-way through the sweep.
        a_raddr0 = 8'h10; a_raddr1 = 8'h05;
        tick();
        check("pre_reset_out0", a_out0, 16'hA5A5);
        #2 Reset = 1'b0;
        #1;
        check("async_reset_out0", a_out0, 0);
        check("async_reset_out1", a_out1, 0);
        check("async_reset_done", a_done, 0);
        tick();
        Reset = 1'b1;
        repeat (100) tick();
        check("mid_sweep_done", a_done, 0);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        wait_sweep(n, zero_ok);
        check("restart_cycles", n, 256);
        check("restart_outputs_zero", {31'b0, zero_ok}, 1);
        tick();
        check("restart_read_10", a_out0, 0);
        check("restart_read_05", a_out1, 0);
        $display("txn restart: cycles=%0d out0=%h out1=%h", n, a_out0, a_out1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
